perceptron_driver: RTL and testbench
====================================

Name: perceptron_driver

Overview:
Initiator and collector for the perceptron block. It loads the bias and weights through the W1W0b_en/b/W0/W1 port set. It then streams (X0, X1) samples into the perceptron over val/rdy and collects the Y decisions on the return val/rdy channel. Each decision is compared against an expected label held in a label FIFO, and the block keeps response and mismatch counts. It sits between a testbench- or host-side sample source and perceptron_top, driving the opposite end of both perceptron handshakes.

Parameters:
WIDTH, 8, sample width; matches the perceptron WIDTH
DEPTH, 4, label FIFO depth (power of 2, >=2); maximum number of samples in flight
CNTW, 16, width of the response and mismatch counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_b_i  in  1  bias bit to load
cfg_W0_i  in  1  W0 bit to load
cfg_W1_i  in  1  W1 bit to load
cfg_go_i  in  1  pulse; starts weight load, then RUN (honoured in IDLE only)
cfg_stop_i  in  1  pulse; RUN -> DRAIN
smp_val_i  in  1  sample valid
smp_rdy_o  out  1  sample ready
smp_X0_i  in  WIDTH  signed sample X0
smp_X1_i  in  WIDTH  signed sample X1
smp_label_i  in  1  expected Y for the sample
W1W0b_en_o  out  2  weight load select: 01=b, 10=W0, 11=W1, 00=none
b_o / W0_o / W1_o  out  1 each  weight data, valid while the matching select is asserted
val_o  out  1  sample valid to perceptron
rdy_i  in  1  perceptron ready
X0_o / X1_o  out  WIDTH each  registered sample to perceptron
val_i  in  1  decision valid from perceptron
rdy_o  out  1  decision ready
Y_i  in  1  perceptron decision
busy_o  out  1  state != IDLE
resp_cnt_o  out  CNTW  decisions received, saturating
miss_cnt_o  out  CNTW  decisions where Y_i != label, saturating
orphan_o  out  1  sticky: decision received while label FIFO empty

Behaviour:
- Reset (synchronous, active-high) returns the block to IDLE. All outputs reset to 0, and the FIFO pointers and count go to 0.
- Reset mid-stream discards the in-flight sample and all queued labels. Reset has priority over every other input.
- States: IDLE, LD_B, LD_W0, LD_W1, RUN, DRAIN.
- IDLE: on cfg_go_i, capture cfg_b/W0/W1 and go to LD_B. All other inputs are ignored.
- LD_B, LD_W0, LD_W1: one cycle each. W1W0b_en_o = 01, 10 and 11 respectively, with the matching data output driven from the captured value. LD_W1 -> RUN.
- W1W0b_en_o = 00 in every other state. cfg_go_i during load or RUN is ignored.
- Output register: accept = RUN && smp_val_i && smp_rdy_o.
  - smp_rdy_o = RUN && (!val_o || rdy_i) && (lbl_cnt < DEPTH).
  - On accept: X0_o/X1_o are loaded, val_o is set, and smp_label_i is pushed to the label FIFO in the same cycle.
  - val_o is cleared on val_o && rdy_i when no new accept happens in that cycle.
  - X0_o/X1_o stay stable while val_o && !rdy_i.
- Latency: sample presented at cycle n -> val_o at n+1.
- rdy_o = 1 in RUN and DRAIN, 0 in IDLE and in the load states.
- Decision handshake (val_i && rdy_o):
  - Pop the FIFO head and increment resp_cnt_o.
  - Increment miss_cnt_o if Y_i != head.
  - Both counters hold at all-ones.
  - If the FIFO is empty: set orphan_o, no pop, resp_cnt_o still increments, miss_cnt_o unchanged.
- Full boundary: a push is blocked whenever lbl_cnt == DEPTH, even if a pop happens in the same cycle. This is a deliberate conservative gate.
- Simultaneous push and pop: lbl_cnt unchanged. Pointers wrap modulo DEPTH.
- cfg_stop_i in RUN -> DRAIN. No new samples are accepted in DRAIN, and any pending val_o still completes.
- DRAIN -> IDLE when !val_o && lbl_cnt == 0, evaluated after the current cycle's pop.
- Counters and orphan_o are cleared only by reset. A new cfg_go_i does not clear them.

Decomposition:
- Shared package perceptron_pkg holds:
  - state encoding constants;
  - W1W0b_en encodings SEL_NONE=00, SEL_B=01, SEL_W0=10, SEL_W1=11, which must be shared with perceptron_ctrl/perceptron_dp.
- One sub-module: perceptron_lbl_fifo (1-bit wide, DEPTH entries; push/pop/full/empty/count).

Test Plan:
- Reset, then cfg_go_i with b=1, W0=0, W1=1 -> W1W0b_en_o = 01, 10, 11 on three consecutive cycles with b_o=1, W0_o=0, W1_o=1; busy_o=1; rdy_o=1 from the next cycle.
- RUN, samples (5,-3,label 1) and (-7,2,label 0) back-to-back with rdy_i=1; perceptron returns Y=1 then Y=1 -> resp_cnt_o=2, miss_cnt_o=1.
- rdy_i=0 held for 3 cycles with sample (10,10) pending -> X0_o/X1_o stay at 10/10, val_o stays 1, smp_rdy_o=0; the sample transfers the cycle rdy_i returns to 1.
- DEPTH=4, 4 samples accepted, no decisions returned -> smp_rdy_o=0 after the 4th; one decision then one new sample -> accepted one cycle after the pop.
- val_i=1 with the FIFO empty -> orphan_o=1 (sticky), resp_cnt_o +1, miss_cnt_o unchanged.
- cfg_stop_i with 2 labels queued -> DRAIN, smp_rdy_o=0; IDLE the cycle after the 2nd decision. Separately: reset mid-DRAIN -> IDLE and all counters 0 next cycle.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared encodings for the perceptron driver, controller and datapath.
package perceptron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_B  = 3'd1,
        ST_LD_W0 = 3'd2,
        ST_LD_W1 = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_W0   = 2'b10;
    localparam logic [1:0] SEL_W1   = 2'b11;

endpackage

// File: rtl/perceptron_lbl_fifo.sv
// 1-bit label FIFO holding the expected decision for every sample in flight.
module perceptron_lbl_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_din,
    input  logic          i_pop,
    output logic          o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/perceptron_driver.sv
// Loads perceptron weights, streams samples in and scores the returned decisions.
module perceptron_driver
    import perceptron_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_b_i,
    input  logic             cfg_W0_i,
    input  logic             cfg_W1_i,
    input  logic             cfg_go_i,
    input  logic             cfg_stop_i,
    input  logic             smp_val_i,
    output logic             smp_rdy_o,
    input  logic [WIDTH-1:0] smp_X0_i,
    input  logic [WIDTH-1:0] smp_X1_i,
    input  logic             smp_label_i,
    output logic [1:0]       W1W0b_en_o,
    output logic             b_o,
    output logic             W0_o,
    output logic             W1_o,
    output logic             val_o,
    input  logic             rdy_i,
    output logic [WIDTH-1:0] X0_o,
    output logic [WIDTH-1:0] X1_o,
    input  logic             val_i,
    output logic             rdy_o,
    input  logic             Y_i,
    output logic             busy_o,
    output logic [CNTW-1:0]  resp_cnt_o,
    output logic [CNTW-1:0]  miss_cnt_o,
    output logic             orphan_o
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t        r_state;
    logic          r_w0;
    logic          r_w1;
    logic          w_acc;
    logic          w_dec;
    logic          w_pop;
    logic          w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_cnt;
    logic          w_drained;

    // Full gate ignores a same-cycle pop on purpose: keeps ready off the pop path.
    assign smp_rdy_o = (r_state == ST_RUN) && (!val_o || rdy_i) && !w_full;
    assign w_acc     = smp_val_i && smp_rdy_o;
    assign w_dec     = val_i && rdy_o;
    assign w_pop     = w_dec && !w_empty;
    assign busy_o    = (r_state != ST_IDLE);
    // No pushes in DRAIN, so the FIFO empties this cycle iff count equals pop.
    assign w_drained = !(val_o && !rdy_i) && (w_cnt == CW'(w_pop));

    perceptron_lbl_fifo #(.DEPTH(DEPTH)) u_lbl_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_acc),
        .i_din   (smp_label_i),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_w0       <= 1'b0;
            r_w1       <= 1'b0;
            W1W0b_en_o <= SEL_NONE;
            b_o        <= 1'b0;
            W0_o       <= 1'b0;
            W1_o       <= 1'b0;
            rdy_o      <= 1'b0;
        end else begin
            W1W0b_en_o <= SEL_NONE;
            b_o        <= 1'b0;
            W0_o       <= 1'b0;
            W1_o       <= 1'b0;
            case (r_state)
                ST_IDLE: if (cfg_go_i) begin
                    r_state    <= ST_LD_B;
                    r_w0       <= cfg_W0_i;
                    r_w1       <= cfg_W1_i;
                    W1W0b_en_o <= SEL_B;
                    b_o        <= cfg_b_i;
                end
                ST_LD_B: begin
                    r_state    <= ST_LD_W0;
                    W1W0b_en_o <= SEL_W0;
                    W0_o       <= r_w0;
                end
                ST_LD_W0: begin
                    r_state    <= ST_LD_W1;
                    W1W0b_en_o <= SEL_W1;
                    W1_o       <= r_w1;
                end
                ST_LD_W1: begin
                    r_state <= ST_RUN;
                    rdy_o   <= 1'b1;
                end
                ST_RUN: if (cfg_stop_i)
                    r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drained) begin
                    r_state <= ST_IDLE;
                    rdy_o   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_o <= 1'b0;
            X0_o  <= '0;
            X1_o  <= '0;
        end else if (w_acc) begin
            val_o <= 1'b1;
            X0_o  <= smp_X0_i;
            X1_o  <= smp_X1_i;
        end else if (val_o && rdy_i) begin
            val_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_cnt_o <= '0;
            miss_cnt_o <= '0;
            orphan_o   <= 1'b0;
        end else if (w_dec) begin
            if (resp_cnt_o != '1)
                resp_cnt_o <= resp_cnt_o + 1'b1;
            if (w_empty)
                orphan_o <= 1'b1;
            else if ((Y_i != w_head) && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_perceptron_driver.sv
// Directed bench for perceptron_driver: load, streaming, stall, full, orphan, drain, reset.
module tb_perceptron_driver;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_b_i, cfg_W0_i, cfg_W1_i, cfg_go_i, cfg_stop_i;
    logic              smp_val_i, smp_label_i;
    logic              smp_rdy_o;
    logic signed [7:0] smp_X0_i, smp_X1_i;
    logic [1:0]        W1W0b_en_o;
    logic              b_o, W0_o, W1_o;
    logic              val_o, rdy_i, val_i, rdy_o, Y_i, busy_o, orphan_o;
    logic [7:0]        X0_o, X1_o;
    logic [15:0]       resp_cnt_o, miss_cnt_o;

    int errs = 0;
    int checks = 0;

    perceptron_driver #(.WIDTH(8), .DEPTH(4), .CNTW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_b_i     (cfg_b_i),
        .cfg_W0_i    (cfg_W0_i),
        .cfg_W1_i    (cfg_W1_i),
        .cfg_go_i    (cfg_go_i),
        .cfg_stop_i  (cfg_stop_i),
        .smp_val_i   (smp_val_i),
        .smp_rdy_o   (smp_rdy_o),
        .smp_X0_i    (smp_X0_i),
        .smp_X1_i    (smp_X1_i),
        .smp_label_i (smp_label_i),
        .W1W0b_en_o  (W1W0b_en_o),
        .b_o         (b_o),
        .W0_o        (W0_o),
        .W1_o        (W1_o),
        .val_o       (val_o),
        .rdy_i       (rdy_i),
        .X0_o        (X0_o),
        .X1_o        (X1_o),
        .val_i       (val_i),
        .rdy_o       (rdy_o),
        .Y_i         (Y_i),
        .busy_o      (busy_o),
        .resp_cnt_o  (resp_cnt_o),
        .miss_cnt_o  (miss_cnt_o),
        .orphan_o    (orphan_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic b, input logic w0, input logic w1);
        cfg_b_i = b; cfg_W0_i = w0; cfg_W1_i = w1; cfg_go_i = 1'b1;
        tick();
        cfg_go_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {cfg_b_i, cfg_W0_i, cfg_W1_i, cfg_go_i, cfg_stop_i} = '0;
        smp_val_i = 0; smp_label_i = 0; smp_X0_i = 0; smp_X1_i = 0;
        rdy_i = 0; val_i = 0; Y_i = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_en", W1W0b_en_o, 0);
        check("rst_val", val_o, 0);
        check("rst_rdy", rdy_o, 0);
        check("rst_smp_rdy", smp_rdy_o, 0);
        check("rst_resp", resp_cnt_o, 0);
        check("rst_miss", miss_cnt_o, 0);
        check("rst_orphan", orphan_o, 0);

        // weight load b=1 W0=0 W1=1
        load(1'b1, 1'b0, 1'b1);
        check("ld_b_en", W1W0b_en_o, 2'b01);
        check("ld_b_dat", b_o, 1);
        check("ld_busy", busy_o, 1);
        check("ld_rdy", rdy_o, 0);
        tick();
        check("ld_w0_en", W1W0b_en_o, 2'b10);
        check("ld_w0_dat", W0_o, 0);
        tick();
        check("ld_w1_en", W1W0b_en_o, 2'b11);
        check("ld_w1_dat", W1_o, 1);
        tick();
        check("run_en", W1W0b_en_o, 2'b00);
        check("run_rdy", rdy_o, 1);

        // two back-to-back samples
        rdy_i = 1; smp_val_i = 1; smp_X0_i = 5; smp_X1_i = -3; smp_label_i = 1;
        #1 check("s1_smp_rdy", smp_rdy_o, 1);
        tick();
        check("s1_val", val_o, 1);
        check("s1_x0", X0_o, 8'h05);
        check("s1_x1", X1_o, 8'hFD);
        smp_X0_i = -7; smp_X1_i = 2; smp_label_i = 0;
        tick();
        check("s2_val", val_o, 1);
        check("s2_x0", X0_o, 8'hF9);
        check("s2_x1", X1_o, 8'h02);
        smp_val_i = 0;
        tick();
        check("s2_done", val_o, 0);
        val_i = 1; Y_i = 1;
        tick();
        check("d1_resp", resp_cnt_o, 1);
        check("d1_miss", miss_cnt_o, 0);
        tick();
        val_i = 0;
        check("d2_resp", resp_cnt_o, 2);
        check("d2_miss", miss_cnt_o, 1);

        // stall with (10,10) held in the output register
        rdy_i = 0; smp_val_i = 1; smp_X0_i = 10; smp_X1_i = 10; smp_label_i = 1;
        #1 check("st_accept_rdy", smp_rdy_o, 1);
        tick();
        smp_val_i = 0;
        for (int i = 0; i < 3; i++) begin
            check("st_val", val_o, 1);
            check("st_x0", X0_o, 8'h0A);
            check("st_x1", X1_o, 8'h0A);
            check("st_smp_rdy", smp_rdy_o, 0);
            tick();
        end
        rdy_i = 1;
        #1 check("st_release_rdy", smp_rdy_o, 1);
        tick();
        check("st_xfer", val_o, 0);
        val_i = 1; Y_i = 1;
        tick();
        val_i = 0;
        check("st_resp", resp_cnt_o, 3);
        check("st_miss", miss_cnt_o, 1);

        // fill the label FIFO
        for (int k = 1; k <= 4; k++) begin
            smp_val_i = 1; smp_X0_i = 8'(k); smp_X1_i = 0; smp_label_i = 0;
            tick();
        end
        smp_X0_i = 5; smp_label_i = 1;
        #1 check("full_smp_rdy", smp_rdy_o, 0);
        check("full_x0", X0_o, 8'h04);
        tick();
        check("full_val_clr", val_o, 0);
        check("full_hold_x0", X0_o, 8'h04);
        val_i = 1; Y_i = 0;
        #1 check("full_pop_gate", smp_rdy_o, 0);
        tick();
        val_i = 0;
        #1 check("full_after_pop", smp_rdy_o, 1);
        check("full_resp", resp_cnt_o, 4);
        check("full_miss", miss_cnt_o, 1);
        tick();
        check("full_new_val", val_o, 1);
        check("full_new_x0", X0_o, 8'h05);
        smp_val_i = 0;
        val_i = 1; Y_i = 0;
        for (int k = 0; k < 4; k++) tick();
        val_i = 0;
        check("full_drain_resp", resp_cnt_o, 8);
        check("full_drain_miss", miss_cnt_o, 2);

        // orphan decision on empty FIFO
        val_i = 1; Y_i = 1;
        tick();
        val_i = 0;
        check("orph_set", orphan_o, 1);
        check("orph_resp", resp_cnt_o, 9);
        check("orph_miss", miss_cnt_o, 2);
        tick();
        check("orph_sticky", orphan_o, 1);

        // stop with two labels queued
        smp_val_i = 1; smp_X0_i = 20; smp_label_i = 1;
        tick();
        smp_X0_i = 21;
        tick();
        smp_val_i = 0; cfg_stop_i = 1;
        tick();
        cfg_stop_i = 0;
        smp_val_i = 1; smp_X0_i = 99;
        #1 check("dr_busy", busy_o, 1);
        check("dr_rdy", rdy_o, 1);
        check("dr_smp_rdy", smp_rdy_o, 0);
        val_i = 1; Y_i = 1;
        tick();
        check("dr_busy1", busy_o, 1);
        check("dr_noacc", val_o, 0);
        tick();
        val_i = 0; smp_val_i = 0;
        check("dr_idle", busy_o, 0);
        check("dr_rdy_off", rdy_o, 0);
        check("dr_resp", resp_cnt_o, 11);
        check("dr_miss", miss_cnt_o, 2);

        // reload keeps counters; then reset in DRAIN
        load(1'b0, 1'b1, 1'b0);
        check("ld2_b_en", W1W0b_en_o, 2'b01);
        check("ld2_b_dat", b_o, 0);
        tick();
        check("ld2_w0_dat", W0_o, 1);
        tick(); tick();
        check("ld2_resp_kept", resp_cnt_o, 11);
        smp_val_i = 1; smp_X0_i = 7; smp_label_i = 0;
        tick();
        smp_val_i = 0; cfg_stop_i = 1;
        tick();
        cfg_stop_i = 0;
        check("rd_busy", busy_o, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rd_busy0", busy_o, 0);
        check("rd_resp0", resp_cnt_o, 0);
        check("rd_miss0", miss_cnt_o, 0);
        check("rd_orph0", orphan_o, 0);
        check("rd_val0", val_o, 0);
        check("rd_rdy0", rdy_o, 0);

        // queued label discarded by reset: first decision is an orphan
        load(1'b1, 1'b1, 1'b1);
        tick(); tick(); tick();
        val_i = 1; Y_i = 0;
        tick();
        val_i = 0;
        check("rd_orph_after", orphan_o, 1);
        check("rd_resp_after", resp_cnt_o, 1);
        check("rd_miss_after", miss_cnt_o, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
